// File: rtl/instr_fetch_queue_if.sv
// Fetch-unit boundary: instruction-memory read port, redirect/enable controls and decode-side valid/ready.
// master = fetch queue, slave = surrounding pipeline and memory.
interface instr_fetch_queue_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic               fetch_en;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               imem_en;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic               out_ready;
    logic [CNT_W-1:0]   occupancy;

    modport master (
        input  fetch_en, redirect_valid, redirect_pc, imem_rdata, out_ready,
        output imem_en, imem_addr, out_valid, out_instr, out_pc, occupancy
    );

    modport slave (
        output fetch_en, redirect_valid, redirect_pc, imem_rdata, out_ready,
        input  imem_en, imem_addr, out_valid, out_instr, out_pc, occupancy
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: issues reads to a 1-cycle synchronous imem and queues {instr, pc} for decode.
// Head visible 2 cycles after issue; fetch stalls when queued + in-flight entries reach DEPTH.
module instr_fetch_queue #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 4
) (
    input logic                clk,
    input logic                reset,
    instr_fetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    entry_t            mem_q [DEPTH];

    logic [CNT_W:0] pending;
    logic           credit;
    logic           issue;
    logic           push;
    logic           pop;

    // An in-flight read already owns a slot, so it is counted before issuing another.
    assign pending = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    assign credit  = pending < (CNT_W + 1)'(DEPTH);
    assign issue   = bus.fetch_en & ~bus.redirect_valid & ~reset & credit;
    assign push    = inflight_q & ~bus.redirect_valid & ~reset;
    assign pop     = (count_q != '0) & bus.out_ready & ~bus.redirect_valid;

    always_comb begin
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = issue;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        if (bus.redirect_valid) begin
            pc_d       = bus.redirect_pc;
            inflight_d = 1'b0;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (issue) begin
                pc_d          = pc_q + ADDR_W'(1);
                inflight_pc_d = pc_q;
            end
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= '0;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Storage needs no reset: only entries below count_q are ever observed.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{instr: bus.imem_rdata, pc: inflight_pc_q};
    end

    assign bus.imem_en   = issue;
    assign bus.imem_addr = pc_q;
    assign bus.out_valid = (count_q != '0);
    assign bus.out_instr = mem_q[rd_ptr_q].instr;
    assign bus.out_pc    = mem_q[rd_ptr_q].pc;
    assign bus.occupancy = count_q;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: streaming, backpressure, redirect, PC wrap, fetch_en drop, mid-stream reset.
// A behavioural 1-cycle synchronous imem supplies known instruction words per address.
module tb_instr_fetch_queue;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    instr_fetch_queue_if #(.ADDR_W(8), .INSTR_W(16), .DEPTH(4)) bus ();

    instr_fetch_queue #(.ADDR_W(8), .INSTR_W(16), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [15:0] imem_val(input logic [7:0] a);
        if (a == 8'h00) return 16'h1123;
        if (a == 8'h01) return 16'h2456;
        return {a, ~a};
    endfunction

    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_rdata <= imem_val(bus.imem_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.fetch_en = 1'b1; bus.out_ready = 1'b1;
        bus.redirect_valid = 1'b0; bus.redirect_pc = 8'h00; bus.imem_rdata = 16'h0000;
        tick(); tick();
        n_cmp++; if (bus.imem_en !== 1'b0) begin n_bad++; $display("FAIL rst_imem_en got %b want 0", bus.imem_en); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.occupancy !== 3'd0) begin n_bad++; $display("FAIL rst_occupancy got %0d want 0", bus.occupancy); end
    endtask

    task automatic test_stream();
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.imem_en !== 1'b1) begin n_bad++; $display("FAIL str_first_issue got %b want 1", bus.imem_en); end
        n_cmp++; if (bus.imem_addr !== 8'h00) begin n_bad++; $display("FAIL str_first_addr got %h want 00", bus.imem_addr); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL str_early_valid got %b want 0", bus.out_valid); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL str_valid0 got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_instr !== 16'h1123) begin n_bad++; $display("FAIL str_instr0 got %h want 1123", bus.out_instr); end
        n_cmp++; if (bus.out_pc !== 8'h00) begin n_bad++; $display("FAIL str_pc0 got %h want 00", bus.out_pc); end
        tick();
        n_cmp++; if (bus.out_instr !== 16'h2456) begin n_bad++; $display("FAIL str_instr1 got %h want 2456", bus.out_instr); end
        n_cmp++; if (bus.out_pc !== 8'h01) begin n_bad++; $display("FAIL str_pc1 got %h want 01", bus.out_pc); end
        for (int i = 2; i < 8; i++) begin
            tick();
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'(i))
                begin n_bad++; $display("FAIL str_seq v=%b pc=%h want v=1 pc=%h", bus.out_valid, bus.out_pc, 8'(i)); end
            n_cmp++; if (bus.out_instr !== imem_val(8'(i)))
                begin n_bad++; $display("FAIL str_seq_instr got %h want %h", bus.out_instr, imem_val(8'(i))); end
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'h07)
                begin n_bad++; $display("FAIL bp_hold v=%b pc=%h want v=1 pc=07", bus.out_valid, bus.out_pc); end
        end
        n_cmp++; if (bus.occupancy !== 3'd4) begin n_bad++; $display("FAIL bp_occupancy got %0d want 4", bus.occupancy); end
        n_cmp++; if (bus.imem_en !== 1'b0) begin n_bad++; $display("FAIL bp_full_imem_en got %b want 0", bus.imem_en); end
        bus.out_ready = 1'b1;
        #1;
        n_cmp++; if (bus.imem_en !== 1'b0) begin n_bad++; $display("FAIL bp_pop_cycle_imem_en got %b want 0", bus.imem_en); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'(7 + i))
                begin n_bad++; $display("FAIL bp_drain v=%b pc=%h want v=1 pc=%h", bus.out_valid, bus.out_pc, 8'(7 + i)); end
            if (i == 1) begin
                n_cmp++; if (bus.imem_en !== 1'b1) begin n_bad++; $display("FAIL bp_resume_imem_en got %b want 1", bus.imem_en); end
            end
            tick();
        end
    endtask

    task automatic test_redirect_full();
        int waited;
        bus.out_ready = 1'b0;
        waited = 0;
        while (!(bus.occupancy == 3'd3 && bus.imem_en == 1'b0) && waited < 8) begin
            tick();
            waited++;
        end
        n_cmp++; if (bus.occupancy !== 3'd3 || bus.imem_en !== 1'b0)
            begin n_bad++; $display("FAIL rd_setup occ=%0d en=%b want occ=3 en=0", bus.occupancy, bus.imem_en); end
        bus.redirect_valid = 1'b1; bus.redirect_pc = 8'h40; bus.out_ready = 1'b1;
        #1;
        n_cmp++; if (bus.imem_en !== 1'b0) begin n_bad++; $display("FAIL rd_cycle_imem_en got %b want 0", bus.imem_en); end
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        n_cmp++; if (bus.occupancy !== 3'd0 || bus.out_valid !== 1'b0)
            begin n_bad++; $display("FAIL rd_flush occ=%0d v=%b want occ=0 v=0", bus.occupancy, bus.out_valid); end
        n_cmp++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 8'h40)
            begin n_bad++; $display("FAIL rd_issue en=%b addr=%h want en=1 addr=40", bus.imem_en, bus.imem_addr); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rd_stale_valid got %b want 0", bus.out_valid); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'h40)
            begin n_bad++; $display("FAIL rd_target v=%b pc=%h want v=1 pc=40", bus.out_valid, bus.out_pc); end
        n_cmp++; if (bus.out_instr !== imem_val(8'h40))
            begin n_bad++; $display("FAIL rd_target_instr got %h want %h", bus.out_instr, imem_val(8'h40)); end
    endtask

    task automatic test_pc_wrap();
        logic [7:0] exp_pc [4];
        exp_pc[0] = 8'hFE; exp_pc[1] = 8'hFF; exp_pc[2] = 8'h00; exp_pc[3] = 8'h01;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 8'hFE;
        tick();
        bus.redirect_valid = 1'b0;
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc[i])
                begin n_bad++; $display("FAIL wrap_seq v=%b pc=%h want v=1 pc=%h", bus.out_valid, bus.out_pc, exp_pc[i]); end
            if (i < 3) tick();
        end
    endtask

    task automatic test_fetch_en_drop();
        bus.fetch_en = 1'b0;
        tick();
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'h02)
            begin n_bad++; $display("FAIL fe_inflight v=%b pc=%h want v=1 pc=02", bus.out_valid, bus.out_pc); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (bus.out_valid !== 1'b0 || bus.imem_en !== 1'b0)
                begin n_bad++; $display("FAIL fe_idle v=%b en=%b want v=0 en=0", bus.out_valid, bus.imem_en); end
        end
        n_cmp++; if (bus.imem_addr !== 8'h03) begin n_bad++; $display("FAIL fe_pc_hold got %h want 03", bus.imem_addr); end
        bus.fetch_en = 1'b1;
        #1;
        n_cmp++; if (bus.imem_en !== 1'b1) begin n_bad++; $display("FAIL fe_reenable got %b want 1", bus.imem_en); end
        tick(); tick();
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'h03)
            begin n_bad++; $display("FAIL fe_resume v=%b pc=%h want v=1 pc=03", bus.out_valid, bus.out_pc); end
    endtask

    task automatic test_reset_mid();
        int waited;
        bus.out_ready = 1'b0;
        waited = 0;
        while (bus.occupancy != 3'd3 && waited < 8) begin
            tick();
            waited++;
        end
        n_cmp++; if (bus.occupancy !== 3'd3) begin n_bad++; $display("FAIL rm_setup occ=%0d want 3", bus.occupancy); end
        reset = 1'b1;
        #1;
        n_cmp++; if (bus.imem_en !== 1'b0) begin n_bad++; $display("FAIL rm_cycle_imem_en got %b want 0", bus.imem_en); end
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 3'd0)
            begin n_bad++; $display("FAIL rm_flush v=%b occ=%0d want v=0 occ=0", bus.out_valid, bus.occupancy); end
        n_cmp++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 8'h00)
            begin n_bad++; $display("FAIL rm_restart en=%b addr=%h want en=1 addr=00", bus.imem_en, bus.imem_addr); end
        bus.out_ready = 1'b1;
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rm_early_valid got %b want 0", bus.out_valid); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'h00 || bus.out_instr !== 16'h1123)
            begin n_bad++; $display("FAIL rm_first v=%b pc=%h instr=%h want v=1 pc=00 instr=1123",
                                    bus.out_valid, bus.out_pc, bus.out_instr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_pc_wrap();
        test_fetch_en_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
